// File: rtl/rf_tap_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rf_tap_pkg
// Brief    : Shared types and default sizes for the PIRDSP register-file
//            tap reader.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package rf_tap_pkg;

  localparam int RF_WIDTH_DEF = 30;
  localparam int RF_SIZE_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_tap_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rf_tap_reader
// Brief    : Read-side controller for the shift-in register file. Passes the
//            sample stream to the file's shift-write port, tracks the fill
//            level and serves two-tap read commands over valid/ready.
//            Optional macro RF_TAP_READER_FLUSH_EN adds a 'flush' input that
//            clears the fill level.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module rf_tap_reader
  import rf_tap_pkg::*;
#(
  parameter int RF_WIDTH     = RF_WIDTH_DEF,
  parameter int RF_SIZE      = RF_SIZE_DEF,
  parameter int RF_ADDR_SIZE = $clog2(RF_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef RF_TAP_READER_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic [RF_WIDTH-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [RF_WIDTH-1:0]     rf_write_data,
  output logic                    rf_write_enable,
  input  logic [RF_ADDR_SIZE-1:0] cmd_tap_0,
  input  logic [RF_ADDR_SIZE-1:0] cmd_tap_1,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [RF_ADDR_SIZE-1:0] rf_read_addr_0,
  output logic [RF_ADDR_SIZE-1:0] rf_read_addr_1,
  input  logic [RF_WIDTH-1:0]     rf_read_data_0,
  input  logic [RF_WIDTH-1:0]     rf_read_data_1,
  output logic [RF_WIDTH-1:0]     out_data_0,
  output logic [RF_WIDTH-1:0]     out_data_1,
  output logic [1:0]              out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RF_ADDR_SIZE:0]   fill_count
);

  localparam logic [RF_ADDR_SIZE:0] C_FILL_MAX = (RF_ADDR_SIZE+1)'(RF_SIZE);
  localparam logic [RF_ADDR_SIZE:0] C_FILL_ONE = (RF_ADDR_SIZE+1)'(1);

  state_t                r_state;
  logic [1:0]            r_err;
  logic [RF_ADDR_SIZE:0] w_fill_base;
  logic [RF_ADDR_SIZE:0] w_fill_next;
  logic                  w_idle;
  logic                  w_cmd_fire;

  // Both intake paths are open only in IDLE, and never while reset is held,
  // so a pending read can never see its taps shifted underneath it.
  assign w_idle          = (r_state == IDLE) && !rst;
  assign in_ready        = w_idle;
  assign cmd_ready       = w_idle;
  assign rf_write_data   = in_data;
  assign rf_write_enable = in_valid && in_ready;
  assign w_cmd_fire      = cmd_valid && cmd_ready;

  // Next fill level: optional flush first, then a same-cycle write on top.
  always_comb begin
    w_fill_base = fill_count;
`ifdef RF_TAP_READER_FLUSH_EN
    if (flush) begin
      w_fill_base = '0;
    end
`endif
    w_fill_next = w_fill_base;
    if (rf_write_enable && (w_fill_base != C_FILL_MAX)) begin
      w_fill_next = w_fill_base + C_FILL_ONE;
    end
  end

  // Fill level register, saturating at the file depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count <= '0;
    end else begin
      fill_count <= w_fill_next;
    end
  end

  // Command FSM: latch taps and err flags, capture file data one cycle later,
  // then hold the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      rf_read_addr_0 <= '0;
      rf_read_addr_1 <= '0;
      r_err          <= '0;
      out_data_0     <= '0;
      out_data_1     <= '0;
      out_err        <= '0;
      out_valid      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            rf_read_addr_0 <= cmd_tap_0;
            rf_read_addr_1 <= cmd_tap_1;
            // Err check uses the post-write level so tap 0 may hit the
            // sample written on this very edge.
            r_err[0]       <= ({1'b0, cmd_tap_0} >= w_fill_next);
            r_err[1]       <= ({1'b0, cmd_tap_1} >= w_fill_next);
            r_state        <= READ;
          end
        end
        READ: begin
          out_data_0 <= r_err[0] ? '0 : rf_read_data_0;
          out_data_1 <= r_err[1] ? '0 : rf_read_data_1;
          out_err    <= r_err;
          out_valid  <= 1'b1;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_tap_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_rf_tap_reader
// Brief    : Directed self-checking bench for rf_tap_reader with a behavioural
//            8 x 30 shift-in register file beside it.
//            Flush scenario compiled in when RF_TAP_READER_FLUSH_EN is set.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_rf_tap_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
`ifdef RF_TAP_READER_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic [29:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] rf_write_data;
  logic        rf_write_enable;
  logic [2:0]  cmd_tap_0 = '0;
  logic [2:0]  cmd_tap_1 = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  rf_read_addr_0;
  logic [2:0]  rf_read_addr_1;
  logic [29:0] rf_read_data_0;
  logic [29:0] rf_read_data_1;
  logic [29:0] out_data_0;
  logic [29:0] out_data_1;
  logic [1:0]  out_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  fill_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rf_tap_reader dut (
    .clk             (clk),
    .rst             (rst),
`ifdef RF_TAP_READER_FLUSH_EN
    .flush           (flush),
`endif
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .cmd_tap_0       (cmd_tap_0),
    .cmd_tap_1       (cmd_tap_1),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .rf_read_addr_0  (rf_read_addr_0),
    .rf_read_addr_1  (rf_read_addr_1),
    .rf_read_data_0  (rf_read_data_0),
    .rf_read_data_1  (rf_read_data_1),
    .out_data_0      (out_data_0),
    .out_data_1      (out_data_1),
    .out_err         (out_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fill_count      (fill_count)
  );

  // Behavioural shift-in register file; entry 0 is the newest sample.
  // Starts with non-zero garbage so zeroing of unwritten taps is visible.
  logic [29:0] rf_mem [8];
  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = 30'h2AAA_0000 + 30'(i);
  end
  always @(posedge clk) begin
    if (rf_write_enable) begin
      for (int i = 7; i > 0; i--) rf_mem[i] <= rf_mem[i-1];
      rf_mem[0] <= rf_write_data;
    end
  end
  assign rf_read_data_0 = rf_mem[rf_read_addr_0];
  assign rf_read_data_1 = rf_mem[rf_read_addr_1];

  task automatic write_sample(input logic [29:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Issues one command from IDLE, consumes the result immediately and
  // reports whether out_valid rose exactly on the second edge.
  task automatic run_cmd(input logic [2:0] t0, input logic [2:0] t1,
                         output logic [29:0] d0, output logic [29:0] d1,
                         output logic [1:0] e, output bit timing_ok);
    @(negedge clk);
    cmd_tap_0 = t0;
    cmd_tap_1 = t1;
    cmd_valid = 1'b1;
    timing_ok = (cmd_ready === 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    timing_ok &= (out_valid === 1'b0);
    @(posedge clk); #1;
    timing_ok &= (out_valid === 1'b1);
    d0 = out_data_0;
    d1 = out_data_1;
    e  = out_err;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    timing_ok &= (out_valid === 1'b0) && (cmd_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, out_err, fill_count, out_data_0, rf_read_addr_0, cmd_ready, in_ready}
        !== {1'b0, 2'b00, 4'd0, 30'd0, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b err=%b fill=%0d d0=%0d a0=%0d cr=%b ir=%b, required all 0",
               out_valid, out_err, fill_count, out_data_0, rf_read_addr_0, cmd_ready, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({cmd_ready, in_ready} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_release: cmd_ready=%b in_ready=%b, required 1 1", cmd_ready, in_ready);
    end
  endtask

  task automatic test_basic_read();
    logic [29:0] d0, d1;
    logic [1:0]  e;
    bit          ok;
    write_sample(30'd10);
    write_sample(30'd20);
    write_sample(30'd30);
    run_cmd(3'd0, 3'd2, d0, d1, e, ok);
    tests_run++;
    if ({d0, d1, e, ok} !== {30'd30, 30'd10, 2'b00, 1'b1}) begin
      tests_failed++;
      $display("FAIL basic_read: d=(%0d,%0d) err=%b timing=%b, required (30,10) 00 1", d0, d1, e, ok);
    end
    run_cmd(3'd1, 3'd5, d0, d1, e, ok);
    tests_run++;
    if ({d0, d1, e, ok} !== {30'd20, 30'd0, 2'b10, 1'b1}) begin
      tests_failed++;
      $display("FAIL unwritten_tap: d=(%0d,%0d) err=%b timing=%b, required (20,0) 10 1", d0, d1, e, ok);
    end
    tests_run++;
    if (fill_count !== 4'd3) begin
      tests_failed++;
      $display("FAIL fill_three: fill_count=%0d, required 3", fill_count);
    end
  endtask

  task automatic test_saturation();
    logic [29:0] d0, d1;
    logic [1:0]  e;
    bit          ok;
    for (int i = 1; i <= 12; i++) write_sample(30'(i));
    tests_run++;
    if (fill_count !== 4'd8) begin
      tests_failed++;
      $display("FAIL fill_saturate: fill_count=%0d, required 8", fill_count);
    end
    run_cmd(3'd7, 3'd0, d0, d1, e, ok);
    tests_run++;
    if ({d0, d1, e, ok} !== {30'd5, 30'd12, 2'b00, 1'b1}) begin
      tests_failed++;
      $display("FAIL oldest_tap: d=(%0d,%0d) err=%b timing=%b, required (5,12) 00 1", d0, d1, e, ok);
    end
  endtask

  task automatic test_same_cycle();
    bit blocked = 1'b1;
    @(negedge clk);
    in_data   = 30'd99;
    in_valid  = 1'b1;
    cmd_tap_0 = 3'd0;
    cmd_tap_1 = 3'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    // in_valid stays high through READ and HOLD; nothing may be written.
    blocked &= (in_ready === 1'b0) && (rf_write_enable === 1'b0);
    @(posedge clk); #1;
    blocked &= (in_ready === 1'b0) && (rf_write_enable === 1'b0) && (out_valid === 1'b1);
    tests_run++;
    if ({out_data_0, out_data_1, out_err} !== {30'd99, 30'd12, 2'b00}) begin
      tests_failed++;
      $display("FAIL same_cycle_data: d=(%0d,%0d) err=%b, required (99,12) 00",
               out_data_0, out_data_1, out_err);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests_run++;
    if (!blocked || rf_mem[1] !== 30'd12 || fill_count !== 4'd8) begin
      tests_failed++;
      $display("FAIL write_blocked: blocked=%b mem1=%0d fill=%0d, required 1 12 8",
               blocked, rf_mem[1], fill_count);
    end
  endtask

  task automatic test_stall();
    logic [29:0] d0, d1;
    bit stable = 1'b1;
    @(negedge clk);
    cmd_tap_0 = 3'd2;
    cmd_tap_1 = 3'd3;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = 30'd55;
    @(posedge clk); #1;
    d0 = out_data_0;
    d1 = out_data_1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      stable &= (out_valid === 1'b1) && (out_data_0 === d0) && (out_data_1 === d1)
                && (cmd_ready === 1'b0) && (in_ready === 1'b0) && (rf_write_enable === 1'b0);
    end
    tests_run++;
    if ({d0, d1} !== {30'd11, 30'd10} || !stable) begin
      tests_failed++;
      $display("FAIL stall_hold: d=(%0d,%0d) stable=%b, required (11,10) 1", d0, d1, stable);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if ({out_valid, cmd_ready, in_ready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL stall_release: valid=%b cmd_ready=%b in_ready=%b, required 0 1 1",
               out_valid, cmd_ready, in_ready);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [29:0] d0, d1;
    logic [1:0]  e;
    bit          ok;
    @(negedge clk);
    cmd_tap_0 = 3'd0;
    cmd_tap_1 = 3'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, fill_count, cmd_ready, in_ready} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_read: valid=%b fill=%0d cr=%b ir=%b, required 0 0 0 0",
               out_valid, fill_count, cmd_ready, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, cmd_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL dropped_cmd: valid=%b cmd_ready=%b, required 0 1", out_valid, cmd_ready);
    end
    // Empty file: write 77 and command (0,1) together; only tap 1 is unwritten.
    @(negedge clk);
    in_data   = 30'd77;
    in_valid  = 1'b1;
    cmd_tap_0 = 3'd0;
    cmd_tap_1 = 3'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({out_valid, out_data_0, out_data_1, out_err, fill_count}
        !== {1'b1, 30'd77, 30'd0, 2'b10, 4'd1}) begin
      tests_failed++;
      $display("FAIL first_write_err: valid=%b d=(%0d,%0d) err=%b fill=%0d, required 1 (77,0) 10 1",
               out_valid, out_data_0, out_data_1, out_err, fill_count);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_cmd(3'd0, 3'd0, d0, d1, e, ok);
    tests_run++;
    if ({d0, d1, e, ok} !== {30'd77, 30'd77, 2'b00, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_entry: d=(%0d,%0d) err=%b timing=%b, required (77,77) 00 1", d0, d1, e, ok);
    end
  endtask

`ifdef RF_TAP_READER_FLUSH_EN
  task automatic test_flush();
    logic [29:0] d0, d1;
    logic [1:0]  e;
    bit          ok;
    for (int i = 0; i < 8; i++) write_sample(30'(100 + i));
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (fill_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL flush_clear: fill_count=%0d, required 0", fill_count);
    end
    run_cmd(3'd0, 3'd0, d0, d1, e, ok);
    tests_run++;
    if ({d0, d1, e, ok} !== {30'd0, 30'd0, 2'b11, 1'b1}) begin
      tests_failed++;
      $display("FAIL flush_err: d=(%0d,%0d) err=%b timing=%b, required (0,0) 11 1", d0, d1, e, ok);
    end
    write_sample(30'd1);
    write_sample(30'd2);
    @(negedge clk);
    flush    = 1'b1;
    in_data  = 30'd3;
    in_valid = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (fill_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL flush_with_write: fill_count=%0d, required 1", fill_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_read();
    test_saturation();
    test_same_cycle();
    test_stall();
    test_reset_mid_read();
`ifdef RF_TAP_READER_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_tap_reader.md
# rf_tap_reader

Read-side controller for the 8-entry, 30-bit shift-in register file of the PIRDSP datapath. Accepts a sample stream and turns it into the file's shift-write port. Accepts two-tap read commands, drives the file's two read addresses and returns the captured tap pair over a valid/ready handshake. Tracks fill level so reads of never-written entries are flagged and zeroed.

## Interface
- RF_width, 30, data width of one entry
- RF_size, 8, number of entries; tap 0 = newest sample
- RF_addr_size, $clog2(RF_size), address width
- Reset: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  RF_width  sample to shift into the file
- in_valid  input  1  sample present
- in_ready  output  1  sample accepted when in_valid & in_ready
- rf_write_data  output  RF_width  = in_data
- rf_write_enable  output  1  = in_valid & in_ready
- cmd_tap_0, cmd_tap_1  input  RF_addr_size  tap offsets (0 = newest)
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- rf_read_addr_0, rf_read_addr_1  output  RF_addr_size  registered read addresses
- rf_read_data_0, rf_read_data_1  input  RF_width  combinational file read data
- out_data_0, out_data_1  output  RF_width  captured tap values
- out_err  output  2  bit n set: tap n not yet written, out_data_n forced to 0
- out_valid  output  1  result present
- out_ready  input  1  result consumed when out_valid & out_ready
- fill_count  output  RF_addr_size+1  entries written, saturating at RF_size

## Operation
- FSM states IDLE, READ, HOLD. Reset state: IDLE.
- IDLE: cmd_ready=1, in_ready=1. On cmd_valid, latch taps into rf_read_addr_*, latch err bits (tap >= fill_count, using the fill_count after any same-cycle write) and go to READ.
- READ: one cycle. rf_read_addr_* are stable. At the edge, capture rf_read_data_* into out_data_* (zero where err set), set out_valid and go to HOLD.
- HOLD: out_valid=1. Outputs hold until out_ready. On handshake, clear out_valid and go to IDLE.
- in_ready=0 in READ and HOLD, so no shift can corrupt a pending read. cmd_ready=0 outside IDLE.
- Simultaneous write and command in IDLE: both are accepted. The command addresses post-write contents, so tap 0 is the sample written that cycle. The err check counts that write.
- fill_count increments on each rf_write_enable and saturates at RF_size; writes past RF_size leave it at RF_size.
- in_ready and cmd_ready are forced 0 while rst is high.
- Reset values: rf_read_addr_*=0, out_data_*=0, out_err=0, out_valid=0, fill_count=0. In-flight transactions are dropped.

## Timing
- Command accepted at edge T. READ spans T..T+1. out_valid is high from edge T+1 (2nd edge counting the accept edge).
- Minimum command period: 3 cycles (accept, READ, HOLD with out_ready=1). cmd_ready reasserts the cycle after the output handshake.
- Write path is combinational, with zero latency from in_valid to rf_write_enable. fill_count updates at the write edge.
- out_ready held low stalls the FSM indefinitely in HOLD. Writes stay blocked throughout.

## Configuration
- RF_TAP_READER_FLUSH_EN defined:
  - Adds input port flush (1 bit).
  - flush high at an edge sets fill_count to 0; a same-cycle write is then counted as 1.
  - An in-flight command keeps the err bits latched at accept.
- Undefined: no flush port. fill_count clears only on rst.

## Structure
- Shared package rf_tap_pkg: state enum typedef (IDLE, READ, HOLD), default RF_width/RF_size constants.
- No sub-module. The register file itself is instantiated by the parent, beside this block.

## Test plan
- Reset, then write 10, 20, 30 and issue cmd (0,2) -> out_data=(30,10), out_err=00, out_valid 2 edges after accept.
- After the 3 writes above, cmd (1,5) -> out_data=(20,0), out_err=10, fill_count=3.
- Write 12 samples 1..12 -> fill_count saturates at 8. cmd (7,0) -> (5,12), err=00.
- Same cycle: in_valid (data 99) and cmd (0,1) in IDLE -> tap 0 returns 99. in_ready is low through READ/HOLD, and in_valid held there causes no write.
- Hold out_ready=0 for 5 cycles in HOLD -> out_data stable, cmd_ready=0, in_ready=0. Release -> IDLE next cycle.
- With RF_TAP_READER_FLUSH_EN: fill to 8, pulse flush, cmd (0,0) -> err=11, data 0. Assert rst mid-READ -> out_valid=0, fill_count=0 immediately.
